// File: rtl/shot_link_pkg.sv
// shot_link_pkg: shared link constants and handshake state types.
package shot_link_pkg;
  localparam int CORD_W = 8;
  localparam int LINK_TIMEOUT = 1_000_000;
  typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_REQ, TX_RELEASE} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_PRESENT, RX_ACK} rx_state_t;
endpackage

// File: rtl/shot_link_sync_bit.sv
// sync_bit: multi-flop synchroniser for one asynchronous control bit.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] ff;
  always_ff @(posedge clk or negedge rst)
    if (!rst) ff <= '0;
    else ff <= {ff[SYNC_STAGES-2:0], d};
  assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/shot_link.sv
// shot_link: 4-phase full-duplex shot/verdict link between player boards.
// SHOT_LINK_PARITY_EN adds an even-parity MSB to the link data.
module shot_link #(
  parameter int CORD_W = shot_link_pkg::CORD_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = shot_link_pkg::LINK_TIMEOUT,
`ifdef SHOT_LINK_PARITY_EN
  localparam int LINK_W = CORD_W + 1
`else
  localparam int LINK_W = CORD_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [CORD_W-1:0] tx_cords,
  output logic              tx_done,
  output logic              tx_hit,
  output logic              tx_timeout,
  output logic              rx_valid,
  output logic [CORD_W-1:0] rx_cords,
  input  logic              rx_resp_valid,
  input  logic              rx_resp_hit,
  output logic              rx_par_err,
  output logic              req_out,
  output logic [LINK_W-1:0] data_out,
  input  logic              ack_in,
  input  logic              hit_in,
  input  logic              req_in,
  input  logic [LINK_W-1:0] data_in,
  output logic              ack_out,
  output logic              hit_out
);
  import shot_link_pkg::*;
  localparam bit TMO_EN = TIMEOUT_CYCLES != 0;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  tx_state_t tx_state;
  rx_state_t rx_state;
  logic req_s, ack_s, req_q, par_bad, tmo_hit, warm_done;
  logic [31:0] tmo_cnt;
  logic [2:0] warm;
  logic [LINK_W-1:0] tx_link;
`ifdef SHOT_LINK_PARITY_EN
  assign tx_link = {^tx_cords, tx_cords};
  assign par_bad = ^data_in;
`else
  assign tx_link = tx_cords;
  assign par_bad = 1'b0;
`endif
  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (.clk(clk), .rst(rst), .d(req_in), .q(req_s));
  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (.clk(clk), .rst(rst), .d(ack_in), .q(ack_s));
  assign tmo_hit = TMO_EN && tmo_cnt == TMO_LAST;
  assign warm_done = warm == 3'(SYNC_STAGES);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_state   <= TX_IDLE;
      tx_ready   <= 1'b1;
      data_out   <= '0;
      req_out    <= 1'b0;
      tx_done    <= 1'b0;
      tx_hit     <= 1'b0;
      tx_timeout <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      tx_done    <= 1'b0;
      tx_timeout <= 1'b0;
      tmo_cnt    <= (tx_state == TX_REQ || tx_state == TX_RELEASE) ? tmo_cnt + 32'd1 : '0;
      case (tx_state)
        TX_IDLE:
          if (tx_valid) begin
            data_out <= tx_link;
            tx_ready <= 1'b0;
            tx_state <= TX_SETUP;
          end
        TX_SETUP: begin
          req_out  <= 1'b1;
          tx_state <= TX_REQ;
        end
        TX_REQ:
          if (ack_s || tmo_hit) begin
            tx_hit     <= ack_s ? hit_in : tx_hit;
            tx_done    <= ack_s;
            tx_timeout <= !ack_s;
            req_out    <= 1'b0;
            tmo_cnt    <= '0;
            tx_state   <= TX_RELEASE;
          end
        default:
          if (!ack_s || tmo_hit) begin
            tx_timeout <= ack_s;
            tx_ready   <= 1'b1;
            tmo_cnt    <= '0;
            tx_state   <= TX_IDLE;
          end
      endcase
    end
  // req_q parks at 1 until the synchroniser holds real samples, so a request
  // already high at reset release is never mistaken for a fresh edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_state   <= RX_IDLE;
      rx_valid   <= 1'b0;
      rx_cords   <= '0;
      rx_par_err <= 1'b0;
      ack_out    <= 1'b0;
      hit_out    <= 1'b0;
      req_q      <= 1'b1;
      warm       <= '0;
    end else begin
      rx_par_err <= 1'b0;
      warm       <= warm_done ? warm : warm + 3'd1;
      req_q      <= warm_done ? req_s : 1'b1;
      case (rx_state)
        RX_IDLE:
          if (req_s && !req_q) begin
            rx_cords   <= data_in[CORD_W-1:0];
            rx_par_err <= par_bad;
            rx_valid   <= !par_bad;
            ack_out    <= par_bad;
            hit_out    <= 1'b0;
            rx_state   <= par_bad ? RX_ACK : RX_PRESENT;
          end
        RX_PRESENT:
          if (rx_resp_valid) begin
            hit_out  <= rx_resp_hit;
            rx_valid <= 1'b0;
            ack_out  <= 1'b1;
            rx_state <= RX_ACK;
          end
        default:
          if (!req_s) begin
            ack_out  <= 1'b0;
            hit_out  <= 1'b0;
            rx_state <= RX_IDLE;
          end
      endcase
    end
endmodule

// File: tb/tb_shot_link.sv
// tb_shot_link: randomized self-checking bench playing both main_fsm and the peer board.
module tb_shot_link;
  localparam int CW = 8;
  localparam int SS = 2;
  localparam int TO = 100;
`ifdef SHOT_LINK_PARITY_EN
  localparam int LW = CW + 1;
`else
  localparam int LW = CW;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic tx_valid = 1'b0, rx_resp_valid = 1'b0, rx_resp_hit = 1'b0;
  logic ack_in = 1'b0, hit_in = 1'b0, req_in = 1'b0;
  logic [CW-1:0] tx_cords = '0;
  logic [LW-1:0] data_in = '0;
  logic tx_ready, tx_done, tx_hit, tx_timeout, rx_valid, rx_par_err, req_out, ack_out, hit_out;
  logic [CW-1:0] rx_cords;
  logic [LW-1:0] data_out;
  int checks = 0, failures = 0;

  shot_link #(.CORD_W(CW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_cords(tx_cords),
    .tx_done(tx_done), .tx_hit(tx_hit), .tx_timeout(tx_timeout), .rx_valid(rx_valid),
    .rx_cords(rx_cords), .rx_resp_valid(rx_resp_valid), .rx_resp_hit(rx_resp_hit),
    .rx_par_err(rx_par_err), .req_out(req_out), .data_out(data_out), .ack_in(ack_in),
    .hit_in(hit_in), .req_in(req_in), .data_in(data_in), .ack_out(ack_out), .hit_out(hit_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic logic [LW-1:0] link_of(input logic [CW-1:0] c);
`ifdef SHOT_LINK_PARITY_EN
    return {1'($countones(c) % 2), c};
`else
    return c;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    checks++;
    if ({tx_done, tx_hit, tx_timeout, rx_valid, rx_par_err, req_out, ack_out, hit_out} !== 8'h00) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000000", {tx_done, tx_hit, tx_timeout, rx_valid, rx_par_err, req_out, ack_out, hit_out});
    end
    checks++;
    if (data_out !== '0 || rx_cords !== '0) begin
      failures++; $display("FAIL reset_data got=%h/%h exp=0/0", data_out, rx_cords);
    end
    rst = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_basic_shot(input logic [CW-1:0] c, input logic h, input int d);
    int n;
    tx_cords = c;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    checks++;
    if (data_out !== link_of(c) || req_out !== 1'b0) begin
      failures++; $display("FAIL shot_setup data=%h req=%b exp=%h/0", data_out, req_out, link_of(c));
    end
    tick();
    checks++;
    if (req_out !== 1'b1) begin failures++; $display("FAIL shot_req got=%b exp=1", req_out); end
    tx_cords = ~c;
    tx_valid = 1'b1;
    repeat (d) tick();
    tx_valid = 1'b0;
    ack_in = 1'b1;
    hit_in = h;
    n = 0;
    while (tx_done !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (n != SS + 1) begin failures++; $display("FAIL shot_done_latency got=%0d exp=%0d", n, SS + 1); end
    checks++;
    if (tx_hit !== h || req_out !== 1'b0) begin
      failures++; $display("FAIL shot_verdict hit=%b req=%b exp=%b/0", tx_hit, req_out, h);
    end
    tick();
    checks++;
    if (tx_done !== 1'b0) begin failures++; $display("FAIL shot_done_pulse got=%b exp=0", tx_done); end
    ack_in = 1'b0;
    hit_in = 1'b0;
    n = 0;
    while (tx_ready !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (n != SS + 1) begin failures++; $display("FAIL shot_release_latency got=%0d exp=%0d", n, SS + 1); end
    repeat (3) tick();
    checks++;
    if (data_out !== link_of(c) || req_out !== 1'b0 || tx_ready !== 1'b1 || tx_hit !== h) begin
      failures++;
      $display("FAIL shot_no_queue data=%h req=%b ready=%b hit=%b exp=%h/0/1/%b", data_out, req_out, tx_ready, tx_hit, link_of(c), h);
    end
  endtask

  task automatic test_incoming(input logic [CW-1:0] c, input logic h);
    int n;
    rx_resp_valid = 1'b1;
    rx_resp_hit = 1'b1;
    tick();
    rx_resp_valid = 1'b0;
    checks++;
    if (ack_out !== 1'b0 || hit_out !== 1'b0 || rx_valid !== 1'b0) begin
      failures++; $display("FAIL rx_idle_resp ack=%b hit=%b valid=%b exp=0/0/0", ack_out, hit_out, rx_valid);
    end
    data_in = link_of(c);
    req_in = 1'b1;
    n = 0;
    while (rx_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (n != SS + 1) begin failures++; $display("FAIL rx_latency got=%0d exp=%0d", n, SS + 1); end
    checks++;
    if (rx_cords !== c) begin failures++; $display("FAIL rx_cords got=%h exp=%h", rx_cords, c); end
    data_in = ~data_in;
    repeat (3) tick();
    checks++;
    if (rx_valid !== 1'b1 || rx_cords !== c || ack_out !== 1'b0) begin
      failures++; $display("FAIL rx_hold valid=%b cords=%h ack=%b exp=1/%h/0", rx_valid, rx_cords, ack_out, c);
    end
    rx_resp_valid = 1'b1;
    rx_resp_hit = h;
    tick();
    rx_resp_valid = 1'b0;
    checks++;
    if (ack_out !== 1'b1 || hit_out !== h || rx_valid !== 1'b0) begin
      failures++; $display("FAIL rx_ack ack=%b hit=%b valid=%b exp=1/%b/0", ack_out, hit_out, rx_valid, h);
    end
    req_in = 1'b0;
    n = 0;
    while (ack_out !== 1'b0 && n < 20) begin tick(); n++; end
    checks++;
    if (n != SS + 1 || hit_out !== 1'b0) begin
      failures++; $display("FAIL rx_release latency=%0d hit=%b exp=%0d/0", n, hit_out, SS + 1);
    end
    repeat (3) tick();
  endtask

  task automatic test_duplex(input logic [CW-1:0] c1, input logic h1, input logic [CW-1:0] c2, input logic h2);
    logic got_tx, got_rx, txh, rxh;
    logic [CW-1:0] rxc;
    got_tx = 1'b0; got_rx = 1'b0; txh = 1'b0; rxh = 1'b0; rxc = '0;
    tx_cords = c1;
    tx_valid = 1'b1;
    data_in = link_of(c2);
    req_in = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (tx_done === 1'b1) begin got_tx = 1'b1; txh = tx_hit; end
      if (req_out === 1'b1 && !ack_in) begin ack_in = 1'b1; hit_in = h1; end
      if (got_tx && ack_in && req_out === 1'b0) begin ack_in = 1'b0; hit_in = 1'b0; end
      if (rx_valid === 1'b1) rxc = rx_cords;
      rx_resp_valid = rx_valid;
      rx_resp_hit = h2;
      if (ack_out === 1'b1 && req_in) begin got_rx = 1'b1; rxh = hit_out; req_in = 1'b0; end
      if (got_tx && got_rx && tx_ready === 1'b1 && ack_out === 1'b0 && !ack_in && !req_in) break;
      tick();
    end
    rx_resp_valid = 1'b0;
    checks++;
    if (!got_tx || txh !== h1) begin failures++; $display("FAIL duplex_tx done=%b hit=%b exp=1/%b", got_tx, txh, h1); end
    checks++;
    if (!got_rx || rxh !== h2 || rxc !== c2) begin
      failures++; $display("FAIL duplex_rx ack=%b hit=%b cords=%h exp=1/%b/%h", got_rx, rxh, rxc, h2, c2);
    end
    checks++;
    if (tx_ready !== 1'b1 || ack_out !== 1'b0 || data_out !== link_of(c1)) begin
      failures++; $display("FAIL duplex_idle ready=%b ack=%b data=%h exp=1/0/%h", tx_ready, ack_out, data_out, link_of(c1));
    end
    repeat (3) tick();
  endtask

  task automatic test_timeout;
    int n;
    tx_cords = 8'h5C;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    n = 0;
    while (tx_timeout !== 1'b1 && n < 3 * TO) begin tick(); n++; end
    checks++;
    if (n != TO) begin failures++; $display("FAIL timeout_req_latency got=%0d exp=%0d", n, TO); end
    checks++;
    if (req_out !== 1'b0 || tx_done !== 1'b0) begin
      failures++; $display("FAIL timeout_req_drop req=%b done=%b exp=0/0", req_out, tx_done);
    end
    tick();
    checks++;
    if (tx_ready !== 1'b1 || tx_timeout !== 1'b0) begin
      failures++; $display("FAIL timeout_req_idle ready=%b tmo=%b exp=1/0", tx_ready, tx_timeout);
    end
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    ack_in = 1'b1;
    hit_in = 1'b1;
    n = 0;
    while (tx_done !== 1'b1 && n < 20) begin tick(); n++; end
    n = 0;
    while (tx_timeout !== 1'b1 && n < 3 * TO) begin tick(); n++; end
    checks++;
    if (n != TO || tx_ready !== 1'b1) begin
      failures++; $display("FAIL timeout_release latency=%0d ready=%b exp=%0d/1", n, tx_ready, TO);
    end
    ack_in = 1'b0;
    hit_in = 1'b0;
    repeat (5) tick();
    checks++;
    if (tx_ready !== 1'b1 || req_out !== 1'b0 || tx_timeout !== 1'b0) begin
      failures++; $display("FAIL timeout_recover ready=%b req=%b tmo=%b exp=1/0/0", tx_ready, req_out, tx_timeout);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    data_in = link_of(8'h4E);
    req_in = 1'b1;
    n = 0;
    while (rx_valid !== 1'b1 && n < 20) begin tick(); n++; end
    rx_resp_valid = 1'b1;
    rx_resp_hit = 1'b1;
    tick();
    rx_resp_valid = 1'b0;
    tx_cords = 8'h19;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    checks++;
    if (ack_out !== 1'b1 || req_out !== 1'b1) begin
      failures++; $display("FAIL midrst_setup ack=%b req=%b exp=1/1", ack_out, req_out);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (req_out !== 1'b0 || ack_out !== 1'b0 || tx_ready !== 1'b1 || hit_out !== 1'b0) begin
      failures++; $display("FAIL midrst_async req=%b ack=%b ready=%b hit=%b exp=0/0/1/0", req_out, ack_out, tx_ready, hit_out);
    end
    tick();
    rst = 1'b1;
    repeat (10) tick();
    checks++;
    if (rx_valid !== 1'b0 || ack_out !== 1'b0 || rx_par_err !== 1'b0) begin
      failures++; $display("FAIL midrst_no_capture valid=%b ack=%b perr=%b exp=0/0/0", rx_valid, ack_out, rx_par_err);
    end
    req_in = 1'b0;
    repeat (4) tick();
    req_in = 1'b1;
    n = 0;
    while (rx_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (n != SS + 1 || rx_cords !== 8'h4E) begin
      failures++; $display("FAIL midrst_recapture latency=%0d cords=%h exp=%0d/4e", n, rx_cords, SS + 1);
    end
    rx_resp_valid = 1'b1;
    rx_resp_hit = 1'b0;
    tick();
    rx_resp_valid = 1'b0;
    req_in = 1'b0;
    repeat (6) tick();
  endtask

`ifdef SHOT_LINK_PARITY_EN
  task automatic test_parity;
    int n;
    data_in = 9'h037;
    req_in = 1'b1;
    n = 0;
    while (rx_par_err !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (n != SS + 1) begin failures++; $display("FAIL parity_latency got=%0d exp=%0d", n, SS + 1); end
    checks++;
    if (rx_valid !== 1'b0 || ack_out !== 1'b1 || hit_out !== 1'b0) begin
      failures++; $display("FAIL parity_ack valid=%b ack=%b hit=%b exp=0/1/0", rx_valid, ack_out, hit_out);
    end
    tick();
    checks++;
    if (rx_par_err !== 1'b0 || rx_valid !== 1'b0) begin
      failures++; $display("FAIL parity_pulse perr=%b valid=%b exp=0/0", rx_par_err, rx_valid);
    end
    req_in = 1'b0;
    repeat (5) tick();
    checks++;
    if (ack_out !== 1'b0) begin failures++; $display("FAIL parity_release ack=%b exp=0", ack_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_shot(8'h37, 1'b1, 5);
    for (int i = 0; i < 3; i++)
      test_basic_shot(CW'($urandom), 1'($urandom), int'($urandom_range(1, 6)));
    test_incoming(8'hA2, 1'b0);
    for (int i = 0; i < 3; i++)
      test_incoming(CW'($urandom), 1'($urandom));
    for (int i = 0; i < 3; i++)
      test_duplex(CW'($urandom), 1'($urandom), CW'($urandom), 1'($urandom));
    test_timeout();
    test_reset_mid();
`ifdef SHOT_LINK_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shot_link.md
Name: shot_link

Overview:
- Full-duplex, parametrised request/acknowledge link between two player boards.
- Replaces the single-cycle ready/hit/ship_cords pin exchange with a 4-phase handshake that is safe across boards.
- The TX channel sends our shot coordinate and returns the enemy's hit verdict.
- The RX channel presents the enemy's shot to main_fsm and returns our verdict.
- Sits between main_fsm (control_clk domain) and the inter-board Pmod pins.

Parameters:
- CORD_W, 8, coordinate width ({y[3:0], x[3:0]} packing).
- SYNC_STAGES, 2, synchroniser depth on req_in and ack_in; legal range 2..4.
- TIMEOUT_CYCLES, 1_000_000, TX handshake timeout in clk cycles; 0 disables the timeout.

Ports:
- clk, input, 1: control clock.
- rst, input, 1: asynchronous, active-low reset.
- tx_valid, input, 1: main_fsm requests a shot.
- tx_ready, output, 1: TX idle; a shot is accepted when tx_valid && tx_ready.
- tx_cords, input, CORD_W: shot coordinate.
- tx_done, output, 1: one-cycle pulse when the verdict is received.
- tx_hit, output, 1: verdict; valid from tx_done and held until the next accept.
- tx_timeout, output, 1: one-cycle pulse when a handshake is aborted.
- rx_valid, output, 1: an enemy shot is pending.
- rx_cords, output, CORD_W: enemy coordinate; stable while rx_valid.
- rx_resp_valid, input, 1: main_fsm verdict strobe; only honoured while rx_valid.
- rx_resp_hit, input, 1: our verdict.
- rx_par_err, output, 1: one-cycle parity error pulse.
- req_out, output, 1: outgoing shot request.
- data_out, output, LINK_W: outgoing coordinate bundle.
- ack_in, input, 1: enemy acknowledge (asynchronous).
- hit_in, input, 1: enemy verdict; qualified by ack_in.
- req_in, input, 1: enemy shot request (asynchronous).
- data_in, input, LINK_W: enemy coordinate bundle.
- ack_out, output, 1: our acknowledge.
- hit_out, output, 1: our verdict; qualified by ack_out.

Behaviour:
- Reset values: all outputs 0 except tx_ready = 1. Both FSMs go to IDLE, the timeout counter is cleared, and the synchronisers are cleared to 0.
- req_in and ack_in each pass through SYNC_STAGES flops, giving req_s and ack_s.
- data_in and hit_in are bundled data and are sampled only on the qualifying edge of req_s / ack_s.
- TX FSM:
  - IDLE: tx_ready = 1. On accept, latch tx_cords into data_out and go to SETUP.
  - SETUP: one cycle, data-before-request setup. Go to REQ.
  - REQ: req_out = 1.
    - On ack_s = 1: tx_hit <= hit_in, pulse tx_done, go to RELEASE.
  - RELEASE: req_out = 0.
    - On ack_s = 0: go to IDLE.
  - Timeout: the counter runs in REQ and RELEASE and is cleared on every state change.
    - Reaching TIMEOUT_CYCLES in REQ: pulse tx_timeout, req_out <= 0, go to RELEASE.
    - Reaching TIMEOUT_CYCLES in RELEASE: pulse tx_timeout, go to IDLE.
  - data_out holds its value until the next accept.
- RX FSM:
  - IDLE: on a rising edge of req_s (req_s = 1 and its previous value 0), latch data_in into rx_cords and go to PRESENT.
  - PRESENT: rx_valid = 1.
    - On rx_resp_valid: hit_out <= rx_resp_hit, rx_valid <= 0, go to ACK.
  - ACK: ack_out = 1.
    - On req_s = 0: ack_out <= 0, hit_out <= 0, go to IDLE.
- TX and RX are independent. Simultaneous shots in both directions are legal and neither FSM blocks the other.
- Latency:
  - Accept to req_out high: 2 cycles.
  - Pin edge to FSM reaction: SYNC_STAGES + 1 cycles.
- Boundary conditions:
  - req_in held high at reset release: no capture until req_s has been seen at 0.
  - rx_resp_valid while the RX FSM is not in PRESENT: ignored.
  - tx_valid while not tx_ready: ignored, with no queueing.
  - Reset mid-handshake: req_out and ack_out drop immediately; the peer recovers via its own timeout.

Optional Feature:
- Macro SHOT_LINK_PARITY_EN.
- Defined:
  - LINK_W = CORD_W + 1, with MSB = even parity over the coordinate.
  - On an RX capture with bad parity: pulse rx_par_err, do not assert rx_valid, and go straight to ACK with hit_out = 0. The sender therefore sees a miss.
- Undefined:
  - LINK_W = CORD_W.
  - rx_par_err tied to 0.

Decomposition:
- Add to project_cfg_pkg:
  - CORD_W.
  - Typedef tx_state_t {TX_IDLE, TX_SETUP, TX_REQ, TX_RELEASE}.
  - Typedef rx_state_t {RX_IDLE, RX_PRESENT, RX_ACK}.
  - Default LINK_TIMEOUT.
- One sub-module, sync_bit (parametrised SYNC_STAGES, async active-low reset). It is instanced twice, once for req_in and once for ack_in.

Test Plan:
- Basic shot: tx_cords = 8'h37, tx_valid pulse; peer ack_in rises 5 cycles after req_out with hit_in = 1.
  - Expect data_out = 8'h37 before req_out rises.
  - Expect tx_done pulse with tx_hit = 1.
  - Expect tx_ready again after ack_in falls.
- Incoming shot: data_in = 8'hA2, then req_in rises.
  - Expect rx_valid and rx_cords = 8'hA2 after SYNC_STAGES + 1 cycles.
  - Drive rx_resp_valid with rx_resp_hit = 0: expect ack_out = 1, hit_out = 0; both clear after req_in falls.
- Full duplex: launch a TX shot and an RX shot on the same cycle.
  - Expect both handshakes to complete, with correct hit values in each direction.
- Timeout: TIMEOUT_CYCLES = 100 and ack_in never rises.
  - Expect tx_timeout at REQ + 100 cycles, req_out = 0, then return to IDLE.
- Reset: assert rst mid-REQ and mid-ACK.
  - Expect req_out = 0, ack_out = 0 and tx_ready = 1 asynchronously.
  - Expect no capture while req_in is still high after release.
- Parity (SHOT_LINK_PARITY_EN): data_in = 9'h037 with a flipped parity bit.
  - Expect rx_par_err pulse, no rx_valid, and ack_out = 1 with hit_out = 0.
